fetch_pc_unit: RTL and testbench

Instruction-fetch and program-counter stage that sits directly upstream of the instruction decoder in the MIPS core. It owns the PC, fetches words from instruction memory over a request/ready handshake, presents the latched instruction (and its `op`/`func` fields) to the decoder for one execute cycle, and computes the next PC from the decoder's branch/jump strobes. It also halts the core on the exit syscall and keeps cycle and retired-instruction counters.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_pc_unit_if.sv | 23 ++
 rtl/fetch_pc_unit_next_pc.sv | 57 +++++
 rtl/fetch_pc_unit.sv | 113 +++++++++++
 tb/tb_fetch_pc_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM states, syscall and
// REGIMM constants, and the branch-offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] SYSCALL_EXIT     = 32'd10;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch port between the fetch stage and instruction memory.
interface fetch_pc_unit_if;
    // imem_req/imem_addr are driven by the fetch stage and held stable until a
    // cycle in which imem_ready is high; imem_rdata is valid only in that cycle.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// Combinational next-PC selection: jr, then jump/jal, then taken branch,
// otherwise the sequential PC.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic        beq,
    input  logic        bne,
    input  logic        blez,
    input  logic        bgtz,
    input  logic        bz,
    input  logic        jr,
    input  logic        jmp,
    input  logic        jal,
    input  logic        alu_equal,
    output logic [31:0] next_pc
);

    logic       rs_neg;
    logic       rs_zero;
    logic       regimm_taken;
    logic       taken;
    logic [4:0] rt;

    always_comb begin
        rt      = instr[20:16];
        rs_neg  = rs_val[31];
        rs_zero = (rs_val == 32'd0);

        // bz covers the REGIMM pair; other rt encodings never branch.
        case (rt)
            RT_BLTZ: regimm_taken = rs_neg;
            RT_BGEZ: regimm_taken = !rs_neg;
            default: regimm_taken = 1'b0;
        endcase

        taken = (beq  &&  alu_equal)
             || (bne  && !alu_equal)
             || (blez && (rs_neg || rs_zero))
             || (bgtz && !rs_neg && !rs_zero)
             || (bz   && regimm_taken);

        // jr arrives with jmp also raised, so it must be tested first.
        if (jr) begin
            next_pc = {rs_val[31:2], 2'b00};
        end else if (jmp || jal) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: fetches over the imem handshake, holds the instruction for
// one execute cycle, updates the PC, halts on the exit syscall, counts cycles.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master imem,
    output logic [31:0]     instr,
    output logic [5:0]      op,
    output logic [5:0]      func,
    output logic            instr_valid,
    input  logic            beq,
    input  logic            bne,
    input  logic            blez,
    input  logic            bgtz,
    input  logic            bz,
    input  logic            jr,
    input  logic            jmp,
    input  logic            jal,
    input  logic            syscall,
    input  logic            alu_equal,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     v0_val,
    input  logic            go,
    output logic [31:0]     pc,
    output logic [31:0]     pc_plus4,
    output logic            halted,
    output logic [31:0]     cycle_count,
    output logic [31:0]     instr_count,
    output state_t          state
);

    state_t      state_next;
    logic [31:0] next_pc;
    logic        exit_call;

    assign pc_plus4       = pc + 32'd4;
    assign op             = instr[31:26];
    assign func           = instr[5:0];
    assign imem.imem_addr = pc;
    assign exit_call      = syscall && (v0_val == SYSCALL_EXIT);

    next_pc_calc u_next_pc (
        .pc_plus4  (pc_plus4),
        .instr     (instr),
        .rs_val    (rs_val),
        .beq       (beq),
        .bne       (bne),
        .blez      (blez),
        .bgtz      (bgtz),
        .bz        (bz),
        .jr        (jr),
        .jmp       (jmp),
        .jal       (jal),
        .alu_equal (alu_equal),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem.imem_ready) state_next = EXEC;
            EXEC:    state_next = exit_call ? HALT : FETCH;
            HALT:    if (go) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Outputs are masked while rst_n is low so nothing is requested or
    // strobed during the reset cycle, whatever state the register holds.
    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        if (rst_n) begin
            imem.imem_req = (state == FETCH);
            instr_valid   = (state == EXEC);
            halted        = (state == HALT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (state != HALT) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state == FETCH && imem.imem_ready) begin
                instr <= imem.imem_rdata;
            end
            if (state == EXEC) begin
                instr_count <= instr_count + 32'd1;
                pc          <= exit_call ? pc_plus4 : next_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then randomized instructions,
// checked against an architectural next-PC model.
module tb_fetch_pc_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic        beq = 0, bne = 0, blez = 0, bgtz = 0, bz = 0;
    logic        jr = 0, jmp = 0, jal = 0, syscall = 0, alu_equal = 0, go = 0;
    logic [31:0] rs_val = 0, v0_val = 0;
    logic [31:0] pc, pc_plus4, cycle_count, instr_count;
    logic        halted;
    state_t      dbg_state;

    fetch_pc_unit_if imem_bus ();

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .instr_valid (instr_valid),
        .beq         (beq),
        .bne         (bne),
        .blez        (blez),
        .bgtz        (bgtz),
        .bz          (bz),
        .jr          (jr),
        .jmp         (jmp),
        .jal         (jal),
        .syscall     (syscall),
        .alu_equal   (alu_equal),
        .rs_val      (rs_val),
        .v0_val      (v0_val),
        .go          (go),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .state       (dbg_state)
    );

    int          checks = 0;
    int          fails = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] m_cycles = 0;
    logic [31:0] m_icount = 0;
    logic        m_halted = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Architectural next-PC rule. kind: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz,
    // 5 bz, 6 jr, 7 j, 8 jal.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input int kind, input logic [31:0] rs,
                                             input logic eq, input logic sys,
                                             input logic [31:0] v0);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        int                 rs_s;
        logic               take;
        seq  = cur + 32'd4;
        imm  = w[15:0];
        off  = imm;
        rs_s = rs;
        take = 1'b0;
        if (sys && v0 == 32'd10) return seq;
        if (kind == 6) return rs & 32'hFFFF_FFFC;
        if (kind == 7 || kind == 8) return {seq[31:28], w[25:0], 2'b00};
        case (kind)
            1: take = eq;
            2: take = !eq;
            3: take = (rs_s <= 0);
            4: take = (rs_s > 0);
            5: take = (w[20:16] == 5'd0) ? (rs_s < 0) : (w[20:16] == 5'd1) ? (rs_s >= 0) : 1'b0;
            default: take = 1'b0;
        endcase
        if (take) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic do_instr(input logic [31:0] w, input int waits, input int kind,
                            input logic [31:0] rs, input logic eq, input logic sys,
                            input logic [31:0] v0);
        logic [31:0] exp_w;
        logic [31:0] exp_next;
        exp_q.push_back(w);
        for (int i = 0; i <= waits; i++) begin
            imem_bus.imem_ready = (i == waits);
            imem_bus.imem_rdata = (i == waits) ? w : $urandom();
            #1;
            check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
            check("fetch_addr", imem_bus.imem_addr, m_pc);
            check("fetch_valid", 32'(instr_valid), 32'd0);
            check("fetch_halted", 32'(halted), 32'd0);
            step();
            m_cycles++;
        end
        imem_bus.imem_ready = 1'($urandom_range(0, 1));
        imem_bus.imem_rdata = $urandom();
        beq = (kind == 1); bne = (kind == 2); blez = (kind == 3); bgtz = (kind == 4);
        bz = (kind == 5); jr = (kind == 6); jmp = (kind == 6 || kind == 7); jal = (kind == 8);
        rs_val = rs; alu_equal = eq; syscall = sys; v0_val = v0;
        #1;
        exp_w = exp_q.pop_front();
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req", 32'(imem_bus.imem_req), 32'd0);
        check("exec_instr", instr, exp_w);
        check("exec_op", 32'(op), 32'(exp_w[31:26]));
        check("exec_func", 32'(func), 32'(exp_w[5:0]));
        check("exec_pc", pc, m_pc);
        check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("exec_instr_count", instr_count, m_icount);
        check("exec_cycle_count", cycle_count, m_cycles);
        exp_next = ref_next(m_pc, w, kind, rs, eq, sys, v0);
        step();
        m_cycles++;
        m_icount++;
        m_pc = exp_next;
        m_halted = sys && (v0 == 32'd10);
        {beq, bne, blez, bgtz, bz, jr, jmp, jal, syscall} = '0;
        imem_bus.imem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] rs;
        int          kind;
        logic        sys;

        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'd0;

        // Reset state
        repeat (3) step();
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cycles", cycle_count, 32'd0);
        check("rst_icount", instr_count, 32'd0);
        rst_n = 1'b1;

        // Sequential nops, zero-wait memory
        repeat (3) do_instr(32'h0, 0, 0, 0, 0, 0, 0);
        check("seq_icount", instr_count, 32'd3);
        check("seq_cycles", cycle_count, 32'd6);
        check("seq_pc", pc, 32'h0C);
        do_instr(32'h0, 0, 0, 0, 0, 0, 0);

        // Three wait states at 0x10, then jump to 0x20
        check("wait_pc", pc, 32'h10);
        do_instr(32'h0, 3, 0, 0, 0, 0, 0);
        do_instr({6'h02, 26'h8}, 0, 7, 0, 0, 0, 0);
        check("jmp_pc", pc, 32'h20);

        // Branch back to self, then bgez on a negative value
        do_instr({6'h04, 5'd1, 5'd2, 16'hFFFF}, 1, 1, 0, 1, 0, 0);
        check("beq_pc", pc, 32'h20);
        do_instr({OP_REGIMM, 5'd3, RT_BGEZ, 16'h0010}, 0, 5, 32'h8000_0000, 0, 0, 0);
        check("bgez_pc", pc, 32'h24);

        // jr beats jmp; jal into the low region
        do_instr({6'h00, 5'd4, 15'd0, 6'h08}, 0, 6, 32'h0000_1003, 0, 0, 0);
        check("jr_pc", pc, 32'h1000);
        do_instr({6'h00, 5'd4, 15'd0, 6'h08}, 0, 6, 32'h0040_0000, 0, 0, 0);
        do_instr({6'h03, 26'h100}, 2, 8, 0, 0, 0, 0);
        check("jal_pc", pc, 32'h400);
        do_instr({6'h00, 5'd4, 15'd0, 6'h08}, 0, 6, 32'h30, 0, 0, 0);

        // Exit syscall halts; held go causes one resume
        do_instr(32'h0000_000C, 0, 0, 0, 0, 1, 32'd10);
        for (int i = 0; i < 3; i++) begin
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_bus.imem_req), 32'd0);
            check("halt_cycles", cycle_count, m_cycles);
            check("halt_pc", pc, 32'h34);
            check("halt_state", 32'(dbg_state), 32'(HALT));
            step();
        end
        go = 1'b1;
        step();
        check("go_halted", 32'(halted), 32'd0);
        check("go_req", 32'(imem_bus.imem_req), 32'd1);
        check("go_addr", imem_bus.imem_addr, 32'h34);
        step();
        m_cycles++;
        go = 1'b0;
        check("go_held_addr", imem_bus.imem_addr, 32'h34);
        do_instr(32'h0000_000C, 0, 0, 0, 0, 1, 32'd1);
        check("sys1_pc", pc, 32'h38);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            w    = $urandom();
            kind = $urandom_range(0, 8);
            if (kind == 5) w[20:16] = 5'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = $urandom();
                2:       rs = 32'h8000_0000 | $urandom();
                default: rs = 32'($urandom_range(1, 255));
            endcase
            sys = ($urandom_range(0, 7) == 0);
            do_instr(w, $urandom_range(0, 3), kind, rs, 1'($urandom_range(0, 1)), sys,
                     sys ? 32'($urandom_range(0, 9)) : 32'd10);
        end

        // Reset while waiting on imem_ready, with a late ready in the reset cycle
        step();
        step();
        rst_n = 1'b0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("midrst_req", 32'(imem_bus.imem_req), 32'd0);
        step();
        check("midrst_pc", pc, 32'h0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_cycles", cycle_count, 32'd0);
        check("midrst_icount", instr_count, 32'd0);
        imem_bus.imem_ready = 1'b0;
        rst_n = 1'b1;
        m_pc = 0;
        m_cycles = 0;
        m_icount = 0;
        exp_q.delete();
        do_instr(32'h2408_0005, 1, 0, 0, 0, 0, 0);
        check("post_rst_pc", pc, 32'h4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
